// File: rtl/f_fetch_unit.sv
// Fetch front end: in-order imem requests, response FIFO,
// redirect flush with wrong-path response drop.
module f_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h00003000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        F_Valid,
   output logic [31:0] F_PC,
   output logic [31:0] F_Inst
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   fpc;
   logic [31:0]   pcq [DEPTH];
   logic [AW-1:0] pcq_wr;
   logic [AW-1:0] pcq_rd;
   logic [CW-1:0] outs;
   logic [CW-1:0] drop;
   logic [CW-1:0] count;
   logic [31:0]   fifo_pc [DEPTH];
   logic [31:0]   fifo_inst [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW:0]   credit_used;
   logic          accept;
   logic          push;
   logic          pop;

   // Credits cover both in-flight and buffered words, so the FIFO cannot overflow
   assign credit_used    = {1'b0, outs} + {1'b0, count};
   assign imem_req_valid = rst & ~redirect
                         & (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = fpc;
   assign accept         = imem_req_valid & imem_req_ready;

   assign push = imem_rsp_valid & (drop == '0) & ~redirect;
   assign pop  = F_Valid & ~stall & ~redirect;

   assign F_Valid = (count != '0);
   assign F_PC    = F_Valid ? fifo_pc[rd_ptr] : 32'h0;
   assign F_Inst  = F_Valid ? fifo_inst[rd_ptr] : 32'h0;

   always_ff @(posedge clk) begin
      if (accept) begin
         pcq[pcq_wr] <= fpc;
      end
      if (rst && push) begin
         fifo_pc[wr_ptr]   <= pcq[pcq_rd];
         fifo_inst[wr_ptr] <= imem_rsp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fpc    <= RESET_PC;
         pcq_wr <= '0;
         pcq_rd <= '0;
         outs   <= '0;
         drop   <= '0;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accept) begin
            pcq_wr <= pcq_wr + AW'(1);
         end
         if (imem_rsp_valid) begin
            pcq_rd <= pcq_rd + AW'(1);
         end
         if (accept && !imem_rsp_valid) begin
            outs <= outs + CW'(1);
         end else if (!accept && imem_rsp_valid) begin
            outs <= outs - CW'(1);
         end
         if (redirect) begin
            // stale pc queue entries stay; they pop with the dropped words
            fpc    <= redirect_pc;
            drop   <= outs - CW'(imem_rsp_valid);
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (accept) begin
               fpc <= fpc + 32'd4;
            end
            if (imem_rsp_valid && drop != '0) begin
               drop <= drop - CW'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
               count <= count + CW'(1);
            end else if (pop && !push) begin
               count <= count - CW'(1);
            end
         end
      end
   end

   a_rsp_has_credit: assert property (
      @(posedge clk) disable iff (!rst)
      imem_rsp_valid |-> (outs != '0)
   );

endmodule

// File: tb/tb_f_fetch_unit.sv
// Randomized bench for f_fetch_unit against a queue-based
// model of in-flight requests and the fetch FIFO.
module tb_f_fetch_unit;

   localparam logic [31:0] RPC = 32'h00003000;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        F_Valid;
   logic [31:0] F_PC;
   logic [31:0] F_Inst;

   always #5 clk = ~clk;

   f_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data),
      .F_Valid(F_Valid),
      .F_PC(F_PC),
      .F_Inst(F_Inst)
   );

   typedef struct { logic [31:0] pc; bit wrong; } fl_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } fe_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; int due; } mr_t;

   fl_t inflight[$];
   fe_t fifo[$];
   mr_t mq[$];
   logic [31:0] acc_log[$];

   logic [31:0] m_fpc;
   bit          m_known;
   int          cyc;
   int          n_chk;
   int          n_fail;
   int          lat_min;
   int          lat_max;
   logic [31:0] key;

   logic        s_valid;
   logic        s_rv;
   logic [31:0] s_pc;
   logic [31:0] s_inst;
   logic [31:0] s_addr;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
      end
   endtask

   // One clock: drive memory response, compare at negedge, advance model
   task automatic step();
      bit  exp_rv;
      bit  acc;
      int  d;
      fl_t e;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mq[0].data;
      end
      @(negedge clk);
      s_valid = F_Valid;
      s_rv    = imem_req_valid;
      s_pc    = F_PC;
      s_inst  = F_Inst;
      s_addr  = imem_req_addr;
      exp_rv  = rst && !redirect && (inflight.size() + fifo.size() < DEPTH);
      if (m_known) begin
         check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
         if (exp_rv) check("req_addr", imem_req_addr, m_fpc);
         check("f_valid", 32'(F_Valid), 32'(fifo.size() > 0));
         check("f_pc", F_PC, fifo.size() > 0 ? fifo[0].pc : 32'h0);
         check("f_inst", F_Inst, fifo.size() > 0 ? fifo[0].inst : 32'h0);
      end
      acc = rst && imem_req_valid && imem_req_ready;
      if (!rst) begin
         mq.delete();
      end else begin
         if (imem_rsp_valid) void'(mq.pop_front());
         if (acc) begin
            d = cyc + $urandom_range(lat_max, lat_min);
            if (mq.size() > 0 && mq[$].due > d) d = mq[$].due;
            mq.push_back('{imem_req_addr, imem_req_addr ^ key, d});
            acc_log.push_back(imem_req_addr);
         end
      end
      if (!rst) begin
         m_fpc = RPC;
         inflight.delete();
         fifo.delete();
         m_known = 1'b1;
      end else if (m_known) begin
         if (!redirect && !stall && fifo.size() > 0) void'(fifo.pop_front());
         if (imem_rsp_valid) begin
            check("rsp_credit", 32'(inflight.size() > 0), 32'd1);
            if (inflight.size() > 0) begin
               e = inflight.pop_front();
               if (!e.wrong && !redirect) fifo.push_back('{e.pc, imem_rsp_data});
            end
         end
         if (redirect) begin
            fifo.delete();
            foreach (inflight[i]) inflight[i].wrong = 1'b1;
            m_fpc = redirect_pc;
         end
         if (exp_rv && imem_req_ready) begin
            inflight.push_back('{m_fpc, 1'b0});
            m_fpc = m_fpc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      int n0;
      int k;
      logic [31:0] r;
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      key = 32'h0; lat_min = 1; lat_max = 1;
      cyc = 0; n_chk = 0; n_fail = 0; m_known = 1'b0;
      @(posedge clk);
      #1;
      step();
      step();

      // Reset release and sequential fetch
      rst = 1'b1;
      step();
      check("seq_rv0", 32'(s_rv), 32'd1);
      check("seq_addr0", s_addr, 32'h00003000);
      step();
      check("seq_addr1", s_addr, 32'h00003004);
      step();
      check("seq_fvalid", 32'(s_valid), 32'd1);
      check("seq_fpc", s_pc, 32'h00003000);
      check("seq_finst", s_inst, 32'h00003000);
      repeat (8) step();
      check("seq_acc0", acc_log[0], 32'h00003000);
      check("seq_acc1", acc_log[1], 32'h00003004);
      check("seq_acc2", acc_log[2], 32'h00003008);

      // Stall backpressure
      stall = 1'b1;
      repeat (5) step();
      check("stall_rv", 32'(s_rv), 32'd0);
      check("stall_fvalid", 32'(s_valid), 32'd1);
      stall = 1'b0;
      repeat (6) step();

      // Redirect with two responses in flight
      lat_min = 3; lat_max = 3;
      k = 0;
      while (k < 20 && inflight.size() != 2) begin
         step();
         k++;
      end
      check("redir_outs", 32'(inflight.size()), 32'd2);
      redirect = 1'b1; redirect_pc = 32'h00004000;
      step();
      redirect = 1'b0;
      k = 0;
      do begin
         step();
         k++;
      end while (!s_valid && k < 30);
      check("redir_first_pc", s_pc, 32'h00004000);
      check("redir_first_inst", s_inst, 32'h00004000);

      // Redirect coincident with a response and a stall
      lat_min = 2; lat_max = 2;
      k = 0;
      while (k < 30 && !(mq.size() > 0 && mq[0].due <= cyc)) begin
         step();
         k++;
      end
      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h00005000;
      step();
      check("co_rv", 32'(s_rv), 32'd0);
      redirect = 1'b0; stall = 1'b0;
      step();
      check("co_fvalid", 32'(s_valid), 32'd0);
      k = 0;
      while (!s_valid && k < 30) begin
         step();
         k++;
      end
      check("co_first_pc", s_pc, 32'h00005000);

      // Held request, redirect, PC wrap
      rst = 1'b0;
      step();
      rst = 1'b1; imem_req_ready = 1'b0; lat_min = 1; lat_max = 1;
      repeat (3) begin
         step();
         check("hold_rv", 32'(s_rv), 32'd1);
         check("hold_addr", s_addr, 32'h00003000);
      end
      redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
      step();
      check("wrap_redir_rv", 32'(s_rv), 32'd0);
      redirect = 1'b0; imem_req_ready = 1'b1;
      n0 = acc_log.size();
      repeat (4) step();
      check("wrap_acc0", acc_log[n0], 32'hFFFFFFFC);
      check("wrap_acc1", acc_log[n0+1], 32'h00000000);

      // Reset mid-stream
      lat_min = 2; lat_max = 2;
      k = 0;
      while (k < 20 && !(inflight.size() > 0 && fifo.size() > 0)) begin
         step();
         k++;
      end
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("mid_rst_fvalid", 32'(s_valid), 32'd0);
      check("mid_rst_fpc", s_pc, 32'h0);
      check("mid_rst_finst", s_inst, 32'h0);
      check("mid_rst_rv", 32'(s_rv), 32'd1);
      check("mid_rst_addr", s_addr, 32'h00003000);

      // Randomized traffic
      lat_min = 1; lat_max = 4;
      key = $urandom;
      repeat (3000) begin
         imem_req_ready = ($urandom_range(99, 0) < 70);
         stall          = ($urandom_range(99, 0) < 30);
         redirect       = ($urandom_range(99, 0) < 6);
         r              = $urandom;
         redirect_pc    = r & ~32'h3;
         rst            = ($urandom_range(199, 0) != 0);
         step();
      end
      rst = 1'b1; redirect = 1'b0; stall = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
